uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares one UartTx serializer between NREQ byte-stream requesters, e.g. a console, a debug echo path and a test pattern source.
- Round-robin arbitration with an optional per-requester lock, so a multi-byte message goes out unbroken, capped at MAX_BURST bytes.
- Drives UartTx `data`/`we` and tracks its `ready` to sequence one byte at a time.
- Sits between requester logic and UartTx, in the CLK/RST_X domain from CLKGEN.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MAX_BURST, 16, max consecutive bytes per lock tenure (1..255).

Ports:
- CLK  input  1  system clock.
- RST_X  input  1  reset; synchronous, active-low.
- REQ_VALID  input  NREQ  requester i has a byte on REQ_DATA slice i; held until its ACK.
- REQ_DATA  input  8*NREQ  byte i in bits [8i+7:8i].
- REQ_LOCK  input  NREQ  requester i asks to keep the grant after its current byte.
- REQ_ACK  output  NREQ  one-cycle pulse: byte i accepted.
- TX_DATA  output  8  to UartTx data.
- TX_WE  output  1  to UartTx we; one-cycle pulse.
- TX_READY  input  1  from UartTx ready; high = idle.
- GRANT_ID  output  3  index of the last granted requester.
- BUSY  output  1  high from the TX_WE cycle until TX_READY returns high.

Behaviour:
- Reset (RST_X low at posedge CLK) sets:
  - TX_WE=0, TX_DATA=0, REQ_ACK=0, GRANT_ID=0, BUSY=0.
  - state=IDLE, rr_ptr=NREQ-1, lock_valid=0, lock_owner=0, burst_cnt=0.
- Reset mid-transfer aborts the sequencing; no ACK is issued afterwards. The UartTx line state is UartTx's concern.
- States: IDLE, ISSUE, HOLD, WAIT.
- IDLE: arbitrate when TX_READY=1 and any eligible REQ_VALID. On a decision, at the next edge:
  - register TX_DATA = winner's byte and GRANT_ID = winner;
  - set TX_WE=1, REQ_ACK[winner]=1, BUSY=1;
  - rr_ptr = winner; go to ISSUE.
- Latency: 1 cycle from the valid being sampled to the TX_WE/ACK pulse.
- ISSUE (one cycle): TX_WE and ACK return to 0; go to HOLD.
- HOLD (one cycle): TX_READY is ignored, because UartTx deasserts ready the cycle after WE. Go to WAIT.
- WAIT: stay until TX_READY=1, then set BUSY=0 and go to IDLE. Back-to-back bytes are 4+ cycles apart at minimum; the real spacing is the UART frame time.
- TX_READY low in IDLE: no arbitration and no ACK; requesters wait.
- Round-robin: search indices rr_ptr+1, rr_ptr+2, ... modulo NREQ; the first with REQ_VALID wins. After reset requester 0 has top priority.
- Lock:
  - At a grant, if REQ_LOCK[winner]=1: lock_valid=1, lock_owner=winner, burst_cnt = (same owner as the current lock ? burst_cnt+1 : 1).
  - If REQ_LOCK[winner]=0: lock_valid=0 and burst_cnt=0.
- Arbitration while lock_valid=1:
  - REQ_VALID[owner]=1: owner wins, other requesters ignored.
  - REQ_VALID[owner]=0 and REQ_LOCK[owner]=1: no grant; stay in IDLE and keep the lock.
  - REQ_LOCK[owner]=0: release the lock and arbitrate normally in the same cycle.
- Burst cap: when burst_cnt reaches MAX_BURST at a grant, lock_valid is forced to 0. The next arbitration is normal round-robin, so the owner is lowest priority.
- Simultaneous REQ_VALID on all requesters with no locks: grants rotate 0,1,2,3,0...
- A requester dropping REQ_VALID before its ACK simply loses that arbitration; no error is raised.
- REQ_DATA is sampled only at the decision edge; a requester may change it the cycle after its ACK.
- GRANT_ID holds its value between grants.

Test Plan:
- Requester 1 only, REQ_DATA1=0x61, TX_READY=1 -> next cycle TX_WE=1, TX_DATA=0x61, REQ_ACK=4'b0010, GRANT_ID=1. BUSY stays high until the stubbed TX_READY returns high.
- All four valid (0x41..0x44), no locks, UartTx stub with a 20-cycle busy time -> TX_DATA sequence 0x41,0x42,0x43,0x44, one ACK per grant, TX_WE pulses ≥21 cycles apart.
- Requester 2 locked with 5 bytes 0x30..0x34, requester 0 valid throughout -> all five bytes from 2 in order, then requester 0's byte.
- MAX_BURST=4, requester 3 locked with 6 bytes, requester 1 valid -> 4 bytes from 3, then 1, then the remaining 2 bytes from 3.
- Lock owner drops REQ_VALID but keeps REQ_LOCK for 50 cycles while requester 0 is valid -> no grant to 0 during that window. Owner then deasserts REQ_LOCK -> requester 0 is granted on the next arbitration.
- RST_X low for one cycle during WAIT -> next cycle all outputs are at reset values. Requester 0 valid after reset -> granted first, with a 1-cycle decision latency.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UartTx-side handshake bundle of the UartTx arbiter.
// The arbiter takes the slave modport; the requesters and UartTx together take master.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   REQ_VALID;
    logic [8*NREQ-1:0] REQ_DATA;
    logic [NREQ-1:0]   REQ_LOCK;
    logic [NREQ-1:0]   REQ_ACK;
    logic [7:0]        TX_DATA;
    logic              TX_WE;
    logic              TX_READY;
    logic [2:0]        GRANT_ID;
    logic              BUSY;

    modport master (
        output REQ_VALID, REQ_DATA, REQ_LOCK, TX_READY,
        input  REQ_ACK, TX_DATA, TX_WE, GRANT_ID, BUSY
    );

    modport slave (
        input  REQ_VALID, REQ_DATA, REQ_LOCK, TX_READY,
        output REQ_ACK, TX_DATA, TX_WE, GRANT_ID, BUSY
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one UartTx serializer between NREQ byte-stream requesters using
// round-robin arbitration with an optional per-requester lock capped at MAX_BURST bytes.
module uart_tx_arbiter #(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 16
) (
    input logic              CLK,
    input logic              RST_X,
    uart_tx_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [1:0] WAIT  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [2:0]      rr_ptr_q, rr_ptr_d;
    logic            lock_valid_q, lock_valid_d;
    logic [2:0]      lock_owner_q, lock_owner_d;
    logic [7:0]      burst_cnt_q, burst_cnt_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_we_q, tx_we_d;
    logic [NREQ-1:0] req_ack_q, req_ack_d;
    logic [2:0]      grant_id_q, grant_id_d;
    logic            busy_q, busy_d;

    logic            owner_valid;
    logic            owner_lock;
    logic            rr_found;
    logic [2:0]      rr_winner;
    int              best_dist;
    int              rr_dist;
    logic            grant;
    logic [2:0]      winner;
    logic            lock_live;
    logic [7:0]      win_data;
    logic            win_lock;
    logic [7:0]      burst_next;

    always_comb begin
        owner_valid = 1'b0;
        owner_lock  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (3'(i) == lock_owner_q) begin
                owner_valid = bus.REQ_VALID[i];
                owner_lock  = bus.REQ_LOCK[i];
            end
        end
    end

    // Distance 0 is the index just after rr_ptr, so the last winner ranks lowest.
    always_comb begin
        rr_found  = 1'b0;
        rr_winner = '0;
        best_dist = NREQ;
        rr_dist   = 0;
        for (int i = 0; i < NREQ; i++) begin
            rr_dist = (i + NREQ - 1 - int'(rr_ptr_q)) % NREQ;
            if (bus.REQ_VALID[i] && (rr_dist < best_dist)) begin
                best_dist = rr_dist;
                rr_found  = 1'b1;
                rr_winner = 3'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        lock_valid_d = lock_valid_q;
        lock_owner_d = lock_owner_q;
        burst_cnt_d  = burst_cnt_q;
        tx_data_d    = tx_data_q;
        tx_we_d      = 1'b0;
        req_ack_d    = '0;
        grant_id_d   = grant_id_q;
        busy_d       = busy_q;
        grant        = 1'b0;
        winner       = rr_winner;
        lock_live    = lock_valid_q;
        win_data     = '0;
        win_lock     = 1'b0;
        burst_next   = '0;

        case (state_q)
            IDLE: begin
                if (bus.TX_READY) begin
                    if (lock_valid_q && owner_valid) begin
                        grant  = 1'b1;
                        winner = lock_owner_q;
                    end else if (lock_valid_q && owner_lock) begin
                        grant = 1'b0;
                    end else begin
                        // A dropped lock is released and normal arbitration runs this same cycle.
                        lock_live    = 1'b0;
                        lock_valid_d = 1'b0;
                        grant        = rr_found;
                        winner       = rr_winner;
                    end
                end
            end
            ISSUE:   state_d = HOLD;
            HOLD:    state_d = WAIT;
            WAIT: begin
                if (bus.TX_READY) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        for (int i = 0; i < NREQ; i++) begin
            if (3'(i) == winner) begin
                win_data = bus.REQ_DATA[8*i +: 8];
                win_lock = bus.REQ_LOCK[i];
            end
        end

        if (grant) begin
            state_d    = ISSUE;
            tx_data_d  = win_data;
            grant_id_d = winner;
            tx_we_d    = 1'b1;
            busy_d     = 1'b1;
            rr_ptr_d   = winner;
            for (int i = 0; i < NREQ; i++) begin
                req_ack_d[i] = (3'(i) == winner);
            end
            // Hitting the burst cap drops the lock so the owner falls to lowest priority.
            if (win_lock) begin
                burst_next   = (lock_live && (lock_owner_q == winner)) ? burst_cnt_q + 8'd1 : 8'd1;
                lock_owner_d = winner;
                burst_cnt_d  = burst_next;
                lock_valid_d = (burst_next < 8'(MAX_BURST));
            end else begin
                lock_valid_d = 1'b0;
                burst_cnt_d  = '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            state_q      <= IDLE;
            rr_ptr_q     <= 3'(NREQ - 1);
            lock_valid_q <= 1'b0;
            lock_owner_q <= '0;
            burst_cnt_q  <= '0;
            tx_data_q    <= '0;
            tx_we_q      <= 1'b0;
            req_ack_q    <= '0;
            grant_id_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            lock_valid_q <= lock_valid_d;
            lock_owner_q <= lock_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            tx_data_q    <= tx_data_d;
            tx_we_q      <= tx_we_d;
            req_ack_q    <= req_ack_d;
            grant_id_q   <= grant_id_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.TX_DATA  = tx_data_q;
    assign bus.TX_WE    = tx_we_q;
    assign bus.REQ_ACK  = req_ack_q;
    assign bus.GRANT_ID = grant_id_q;
    assign bus.BUSY     = busy_q;
endmodule
